ballot_issuer: RTL and testbench
================================

BALLOT_ISSUER -- requirements
Module: ballot_issuer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.
REQ-002 Parameter HOLD, default 4: consecutive synchronised cycles a single button must be stable before a vote is issued; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 1000: maximum cycles a ballot may stay open; legal range 2..65535.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 voter_en  input  1  officer request to open one ballot; honoured only in IDLE.
REQ-007 btn  input  4  raw candidate buttons, bit 0 = candidate a ... bit 3 = candidate d; asynchronous to clk.
REQ-008 vote  output  4  one-hot, single-cycle vote pulse; each bit drives the up input of one candidate counter.
REQ-009 ready  output  1  high while in IDLE.
REQ-010 armed  output  1  high while in ARMED or DEBOUNCE.
REQ-011 invalid  output  1  high in ARMED on any cycle where more than one synchronised button is set.
REQ-012 timeout  output  1  one-cycle pulse when a ballot closes without a vote.
REQ-013 votes_cast  output  21  total votes issued since reset; same width as the candidate counters.

Function
REQ-014 btn SHALL pass through a two-flop synchroniser per bit; all decisions use the second-stage value btn_s.
REQ-015 FSM states SHALL be IDLE, ARMED, DEBOUNCE, EMIT and RELEASE, all registered.
REQ-016 IDLE: on voter_en=1, go to ARMED and clear the ballot timer; otherwise stay.
REQ-017 ARMED: if btn_s is exactly one-hot, capture it as choice, set hold count to 1 and go to DEBOUNCE; if btn_s is zero or multi-hot, stay.
REQ-018 DEBOUNCE: btn_s == choice and count == HOLD-1 -> EMIT; btn_s == choice otherwise -> count+1; btn_s != choice -> ARMED with count cleared.
REQ-019 HOLD=1 SHALL go from ARMED directly to EMIT on the capturing edge.
REQ-020 EMIT: vote SHALL equal choice for exactly one cycle, votes_cast SHALL increment by 1 on the exiting edge, and the next state SHALL be RELEASE.
REQ-021 RELEASE: stay while btn_s != 0; go to IDLE on the first cycle btn_s == 0. No second vote is possible per ballot.
REQ-022 The ballot timer SHALL count cycles spent in ARMED and DEBOUNCE; when it reaches TIMEOUT-1, the next state SHALL be IDLE and timeout SHALL pulse for one cycle.
REQ-023 If the timeout condition and the DEBOUNCE-to-EMIT transition occur on the same edge, EMIT SHALL win and timeout SHALL stay low.
REQ-024 voter_en SHALL be ignored in every state except IDLE; a held voter_en re-arms only after RELEASE returns to IDLE.
REQ-025 votes_cast SHALL saturate at 2097151; at saturation a vote pulse is still issued but the count does not wrap.
REQ-026 vote SHALL be zero in every state other than EMIT and never multi-hot.
REQ-027 Latency: with btn stable and one-hot from ARMED entry, vote SHALL assert in the cycle after the (HOLD+2)-th rising edge that samples btn high.

Reset
REQ-028 rst=1 SHALL, from any state, force IDLE, clear the synchroniser, choice, hold count, ballot timer and votes_cast, and drive vote=0, invalid=0, timeout=0, armed=0, ready=1 from the following cycle.
REQ-029 rst asserted during EMIT SHALL suppress the votes_cast increment for that vote.

Verification
REQ-030 Arm, then hold btn=0010 with HOLD=4 -> vote=0010 for one cycle after the 6th sampling edge, votes_cast 0->1, then ready=1 after btn is released plus 3 cycles.
REQ-031 Arm, then btn=0110 for 20 cycles followed by 0000 -> invalid=1 for every ARMED cycle with 0110, vote stays 0, and votes_cast stays 0.
REQ-032 Arm, then btn=0001 for 2 cycles, 0000, then 1000 held -> no vote for 0001; vote=1000 issued exactly once.
REQ-033 Arm with TIMEOUT=10 and no buttons -> timeout pulses once 10 cycles after arming; state is IDLE; votes_cast is unchanged.
REQ-034 Preload votes_cast to 2097151 via repeated ballots (or force), then cast one more vote -> vote pulse issued, votes_cast stays 2097151.
REQ-035 rst for one cycle during DEBOUNCE with a button held -> ready=1, votes_cast=0, and no vote until voter_en is asserted again.

Source files
------------

// File: rtl/ballot_issuer_if.sv
// ballot_issuer_if: signal bundle between the voting-booth controller and
// the officer console / candidate counters.
//   voter_en   officer request to open one ballot
//   btn[3:0]   raw candidate buttons (asynchronous), bit 0 = candidate a
//   vote[3:0]  one-hot single-cycle vote pulse, one bit per candidate counter
//   ready      controller idle, waiting for voter_en
//   armed      ballot open, waiting for a stable single button
//   invalid    more than one button pressed while waiting for a choice
//   timeout    one-cycle pulse, ballot closed without a vote
//   votes_cast total votes issued since reset (saturating)
// master = console/bench side, slave = ballot_issuer.
interface ballot_issuer_if;
  logic        voter_en;
  logic [3:0]  btn;
  logic [3:0]  vote;
  logic        ready;
  logic        armed;
  logic        invalid;
  logic        timeout;
  logic [20:0] votes_cast;

  modport master (
    output voter_en, btn,
    input  vote, ready, armed, invalid, timeout, votes_cast
  );

  modport slave (
    input  voter_en, btn,
    output vote, ready, armed, invalid, timeout, votes_cast
  );
endinterface

// File: rtl/ballot_issuer.sv
// ballot_issuer: issues at most one debounced vote per ballot opened by the
// officer.  Buttons are synchronised, a single button must be stable for HOLD
// synchronised cycles, then a one-cycle one-hot vote pulse is emitted.  The
// voter must release all buttons before the booth can be re-armed.  A ballot
// left open for TIMEOUT cycles closes with a timeout pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ballot_issuer_if.slave (voter_en, btn in; vote, ready, armed,
//        invalid, timeout, votes_cast out)
// Parameters: HOLD 1..255, TIMEOUT 2..65535.
module ballot_issuer #(
  parameter int HOLD    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  ballot_issuer_if.slave bus
);

  localparam logic [20:0] VOTES_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DEBOUNCE, S_EMIT, S_RELEASE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_sync1, r_sync2;
  logic [3:0]  r_choice;
  logic [7:0]  r_count;
  logic [15:0] r_timer;
  logic [20:0] r_votes;
  logic [3:0]  r_vote;
  logic        r_ready, r_armed, r_invalid, r_timeout;

  logic w_s2_onehot, w_s1_multi, w_match, w_hold_done, w_timer_hit;

  assign w_s2_onehot = $onehot(r_sync2);
  // invalid is registered, so it is computed from the btn_s value of the
  // coming cycle (stage 1 now) to line up with the ARMED cycle it flags.
  assign w_s1_multi  = (r_sync1 & (r_sync1 - 4'd1)) != 4'd0;
  assign w_match     = (r_sync2 == r_choice);
  assign w_hold_done = (r_count == 8'(HOLD - 1));
  assign w_timer_hit = (r_timer == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_state   <= S_IDLE;
      r_choice  <= '0;
      r_count   <= '0;
      r_timer   <= '0;
      r_votes   <= '0;
      r_vote    <= '0;
      r_ready   <= 1'b1;
      r_armed   <= 1'b0;
      r_invalid <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync1   <= bus.btn;
      r_sync2   <= r_sync1;
      r_vote    <= '0;
      r_timeout <= 1'b0;
      r_invalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.voter_en) begin
            r_state   <= S_ARMED;
            r_timer   <= '0;
            r_count   <= '0;
            r_ready   <= 1'b0;
            r_armed   <= 1'b1;
            r_invalid <= w_s1_multi;
          end
        end
        S_ARMED: begin
          // Emit takes priority over the timer expiring on the same edge.
          if (w_s2_onehot && HOLD == 1) begin
            r_choice <= r_sync2;
            r_vote   <= r_sync2;
            r_state  <= S_EMIT;
            r_armed  <= 1'b0;
          end else if (w_timer_hit) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_armed   <= 1'b0;
            r_timeout <= 1'b1;
          end else if (w_s2_onehot) begin
            r_choice <= r_sync2;
            r_count  <= 8'd1;
            r_timer  <= r_timer + 16'd1;
            r_state  <= S_DEBOUNCE;
          end else begin
            r_timer   <= r_timer + 16'd1;
            r_invalid <= w_s1_multi;
          end
        end
        S_DEBOUNCE: begin
          if (w_match && w_hold_done) begin
            r_vote  <= r_choice;
            r_state <= S_EMIT;
            r_armed <= 1'b0;
            r_count <= '0;
          end else if (w_timer_hit) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_armed   <= 1'b0;
            r_timeout <= 1'b1;
            r_count   <= '0;
          end else if (w_match) begin
            r_count <= r_count + 8'd1;
            r_timer <= r_timer + 16'd1;
          end else begin
            // A changed button restarts the debounce from ARMED; the ballot
            // timer keeps running.
            r_state   <= S_ARMED;
            r_count   <= '0;
            r_timer   <= r_timer + 16'd1;
            r_invalid <= w_s1_multi;
          end
        end
        S_EMIT: begin
          r_state <= S_RELEASE;
          if (r_votes != VOTES_MAX) r_votes <= r_votes + 21'd1;
        end
        S_RELEASE: begin
          if (r_sync2 == 4'd0) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vote       = r_vote;
  assign bus.ready      = r_ready;
  assign bus.armed      = r_armed;
  assign bus.invalid    = r_invalid;
  assign bus.timeout    = r_timeout;
  assign bus.votes_cast = r_votes;

endmodule

// File: tb/tb_ballot_issuer.sv
// Bench for ballot_issuer: two instances (HOLD=4/TIMEOUT=40 and
// HOLD=1/TIMEOUT=10) share one stimulus stream.  A ballot-level reference
// model (phase + run length of a stable one-hot button) predicts every output
// of both instances each cycle; a vector table and directed sequences add
// hand-derived expectations.
module tb_ballot_issuer;
  localparam int H0 = 4, T0 = 40, H1 = 1, T1 = 10;
  localparam int VMAX = 2097151;
  localparam int P_IDLE = 0, P_OPEN = 1, P_EMIT = 2, P_REL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ballot_issuer_if bus0();
  ballot_issuer_if bus1();

  ballot_issuer #(.HOLD(H0), .TIMEOUT(T0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ballot_issuer #(.HOLD(H1), .TIMEOUT(T1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_pass = 0, n_total = 0;
  logic       t_en;
  logic [3:0] t_btn;

  // reference model state, one entry per instance
  int         m_phase[2], m_run[2], m_open[2], m_votes[2];
  logic [3:0] m_s1[2], m_s2[2], m_choice[2], e_vote[2];
  logic       e_tmo[2];

  typedef struct {
    logic rs; logic en; logic [3:0] b;
    logic e_ready; logic e_armed; logic [3:0] e_vote; logic [20:0] e_votes;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, got, exp);
  endtask

  task automatic model_step(input int k);
    int hold, tmo;
    logic [3:0] bs;
    logic emit;
    hold = (k == 0) ? H0 : H1;
    tmo  = (k == 0) ? T0 : T1;
    if (rst) begin
      m_phase[k] = P_IDLE; m_s1[k] = 0; m_s2[k] = 0; m_run[k] = 0;
      m_open[k] = 0; m_votes[k] = 0; m_choice[k] = 0; e_vote[k] = 0; e_tmo[k] = 0;
    end else begin
      bs = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = t_btn;
      e_vote[k] = 0;
      e_tmo[k] = 0;
      case (m_phase[k])
        P_IDLE: if (t_en) begin m_phase[k] = P_OPEN; m_run[k] = 0; m_open[k] = 0; end
        P_OPEN: begin
          emit = 0;
          if (m_run[k] > 0 && bs == m_choice[k]) begin
            m_run[k]++;
            emit = (m_run[k] == hold);
          end else if (m_run[k] > 0) begin
            m_run[k] = 0;                 // a changed sample is discarded
          end else if ($countones(bs) == 1) begin
            m_choice[k] = bs;
            m_run[k] = 1;
            emit = (hold == 1);
          end
          if (emit) begin
            m_phase[k] = P_EMIT; e_vote[k] = m_choice[k]; m_run[k] = 0;
          end else if (m_open[k] == tmo - 1) begin
            m_phase[k] = P_IDLE; e_tmo[k] = 1;
          end else m_open[k]++;
        end
        P_EMIT: begin
          if (m_votes[k] != VMAX) m_votes[k]++;
          m_phase[k] = P_REL;
        end
        default: if (bs == 0) m_phase[k] = P_IDLE;
      endcase
    end
  endtask

  task automatic cmp_k(input int k, input logic rd, input logic ar, input logic iv,
                       input logic to, input logic [3:0] vt, input logic [20:0] vc);
    check("ready",   k, rd, m_phase[k] == P_IDLE);
    check("armed",   k, ar, m_phase[k] == P_OPEN);
    check("invalid", k, iv, m_phase[k] == P_OPEN && m_run[k] == 0 && $countones(m_s2[k]) > 1);
    check("timeout", k, to, e_tmo[k]);
    check("vote",    k, vt, e_vote[k]);
    check("votes",   k, vc, m_votes[k]);
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input logic rs, input logic en, input logic [3:0] b);
    rst = rs; t_en = en; t_btn = b;
    bus0.voter_en = en; bus1.voter_en = en;
    bus0.btn = b; bus1.btn = b;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    cmp_k(0, bus0.ready, bus0.armed, bus0.invalid, bus0.timeout, bus0.vote, bus0.votes_cast);
    cmp_k(1, bus1.ready, bus1.armed, bus1.invalid, bus1.timeout, bus1.vote, bus1.votes_cast);
  endtask

  task automatic ballot0(input logic [3:0] b, output logic seen, output logic [3:0] vv);
    seen = 0; vv = 0;
    cyc(0, 1, 0);
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 0, b);
      if (bus0.vote != 0) begin seen = 1; vv = bus0.vote; end
    end
    for (int i = 0; i < 10 && !bus0.ready; i++) cyc(0, 0, 0);
  endtask

  initial begin
    logic [20:0] v0;
    logic [3:0]  vv, b;
    logic        seen;
    int          cnt, first, pulses, v1, v8;

    //            rs en  btn   rdy arm vote  votes
    tbl[0]  = '{1, 0, 4'h0, 1, 0, 4'h0, 21'd0};
    tbl[1]  = '{0, 1, 4'h0, 0, 1, 4'h0, 21'd0};
    tbl[2]  = '{0, 0, 4'h2, 0, 1, 4'h0, 21'd0};
    tbl[3]  = '{0, 0, 4'h2, 0, 1, 4'h0, 21'd0};
    tbl[4]  = '{0, 0, 4'h2, 0, 1, 4'h0, 21'd0};
    tbl[5]  = '{0, 0, 4'h2, 0, 1, 4'h0, 21'd0};
    tbl[6]  = '{0, 0, 4'h2, 0, 1, 4'h0, 21'd0};
    tbl[7]  = '{0, 0, 4'h2, 0, 0, 4'h2, 21'd0};
    tbl[8]  = '{0, 0, 4'h2, 0, 0, 4'h0, 21'd1};
    tbl[9]  = '{0, 0, 4'h0, 0, 0, 4'h0, 21'd1};
    tbl[10] = '{0, 0, 4'h0, 0, 0, 4'h0, 21'd1};
    tbl[11] = '{0, 0, 4'h0, 1, 0, 4'h0, 21'd1};

    rst = 1; t_en = 0; t_btn = 0;
    bus0.voter_en = 0; bus1.voter_en = 0; bus0.btn = 0; bus1.btn = 0;
    @(negedge clk);

    // basic ballot, HOLD=4 latency and release
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rs, tbl[i].en, tbl[i].b);
      check("tbl_ready", i, bus0.ready, tbl[i].e_ready);
      check("tbl_armed", i, bus0.armed, tbl[i].e_armed);
      check("tbl_vote",  i, bus0.vote, tbl[i].e_vote);
      check("tbl_votes", i, bus0.votes_cast, tbl[i].e_votes);
    end

    // multi-hot buttons: invalid, no vote, then timeout after 40 cycles
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    v0 = bus0.votes_cast;
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 4'h6);
      check("inv_0110", k, bus0.invalid, k >= 2);
      check("vote_0110", k, bus0.vote, 0);
    end
    cnt = 20; seen = 0;
    for (int j = 0; j < 30 && !seen; j++) begin
      cyc(0, 0, 0);
      cnt++;
      if (bus0.timeout) seen = 1;
    end
    check("tmo40_cycle", 0, cnt, 40);
    check("tmo40_ready", 0, bus0.ready, 1);
    check("tmo40_votes", 0, bus0.votes_cast, v0);

    // timeout on the TIMEOUT=10 instance with no buttons
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    first = 0; pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc(0, 0, 0);
      if (bus1.timeout) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    check("tmo10_cycle", 1, first, 10);
    check("tmo10_pulses", 1, pulses, 1);
    check("tmo10_ready", 1, bus1.ready, 1);
    check("tmo10_votes", 1, bus1.votes_cast, 0);

    // short press below HOLD, gap, then a held press votes exactly once
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    v1 = 0; v8 = 0;
    cyc(0, 0, 4'h1); if (bus0.vote == 4'h1) v1++;
    cyc(0, 0, 4'h1); if (bus0.vote == 4'h1) v1++;
    cyc(0, 0, 4'h0); if (bus0.vote == 4'h1) v1++;
    for (int i = 0; i < 25; i++) begin
      cyc(0, 0, 4'h8);
      if (bus0.vote == 4'h1) v1++;
      if (bus0.vote == 4'h8) v8++;
    end
    check("short_press_votes", 0, v1, 0);
    check("held_press_votes", 0, v8, 1);
    for (int i = 0; i < 10 && !bus0.ready; i++) cyc(0, 0, 0);
    check("held_press_count", 0, bus0.votes_cast, 1);

    // saturation of votes_cast
    cyc(1, 0, 0);
    @(negedge clk);
    force dut0.r_votes = 21'(VMAX - 1);
    m_votes[0] = VMAX - 1;
    cyc(0, 0, 0);
    release dut0.r_votes;
    check("preload", 0, bus0.votes_cast, VMAX - 1);
    ballot0(4'h4, seen, vv);
    check("sat1_vote", 0, vv, 4'h4);
    check("sat1_count", 0, bus0.votes_cast, VMAX);
    ballot0(4'h1, seen, vv);
    check("sat2_vote", 0, vv, 4'h1);
    check("sat2_count", 0, bus0.votes_cast, VMAX);

    // reset in DEBOUNCE with a button held
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'h4);
    check("deb_armed", 0, bus0.armed, 1);
    cyc(1, 0, 4'h4);
    check("rst_ready", 0, bus0.ready, 1);
    check("rst_armed", 0, bus0.armed, 0);
    check("rst_votes", 0, bus0.votes_cast, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 4'h4);
      if (bus0.vote != 0 || !bus0.ready) pulses++;
    end
    check("rst_no_vote", 0, pulses, 0);
    cyc(0, 1, 4'h4);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(0, 0, 4'h4);
      if (bus0.vote == 4'h4) seen = 1;
    end
    check("rearm_vote", 0, seen, 1);
    for (int i = 0; i < 10 && !bus0.ready; i++) cyc(0, 0, 0);

    // randomized traffic against the model
    b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: b = 4'h0;
          1: b = 4'h1 << $urandom_range(0, 3);
          default: b = 4'($urandom_range(0, 15));
        endcase
      end
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
